// File: rtl/game_screen_ctrl_pkg.sv
// Shared definitions for the game screen sequencer: screen state codes and
// the slot order of the concatenated per-screen pixel/address buses.
package game_screen_ctrl_pkg;

    localparam int SCREEN_W = 3;

    typedef enum logic [SCREEN_W-1:0] {
        S_TITLE  = 3'd0,
        S_RECORD = 3'd1,
        S_PLAY   = 3'd2,
        S_OVER   = 3'd3,
        S_PAUSE  = 3'd4
    } state_e;

    // slot index into {over,game,record,title}
    localparam int SLOT_TITLE  = 0;
    localparam int SLOT_RECORD = 1;
    localparam int SLOT_GAME   = 2;
    localparam int SLOT_OVER   = 3;

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Bundle between the per-screen renderers / key inputs and the screen
// sequencer. master = stimulus/environment side, slave = sequencer side.
interface game_screen_ctrl_if
    import game_screen_ctrl_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17
);
    logic [4*PIX_W-1:0]  pixel_in;
    logic [4*ADDR_W-1:0] pixel_addr_in;
    logic                enter;
    logic                select;
    logic                lose;
    logic                pause;
    logic [PIX_W-1:0]    pixel;
    logic [ADDR_W-1:0]   pixel_addr;
    logic                restart;
    logic                record;
    logic                music;
    logic                game_hold;
    logic [SCREEN_W-1:0] screen;

    modport master (
        output pixel_in, pixel_addr_in, enter, select, lose, pause,
        input  pixel, pixel_addr, restart, record, music, game_hold, screen
    );

    modport slave (
        input  pixel_in, pixel_addr_in, enter, select, lose, pause,
        output pixel, pixel_addr, restart, record, music, game_hold, screen
    );
endinterface

// File: rtl/game_screen_ctrl_key_edge.sv
// Rising-edge pulse for a level key. History resets high so a key that is
// already down when reset releases never produces a pulse.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_p
);
    logic key_q;

    // one-cycle key history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_q <= 1'b1;
        else     key_q <= key;
    end

    assign key_p = key & ~key_q;
endmodule

// File: rtl/game_screen_ctrl.sv
// Screen sequencer: picks which renderer drives the VGA pixel register,
// issues restart/record/music strobes and blanks the output for
// BLANK_CYCLES after every screen change.
// Optional pause screen is enabled by defining GAME_PAUSE_EN.
module game_screen_ctrl
    import game_screen_ctrl_pkg::*;
#(
    parameter int PIX_W        = 12,
    parameter int ADDR_W       = 17,
    parameter int BLANK_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    game_screen_ctrl_if.slave bus
);
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    state_e            state_q, state_d;
    logic [BW-1:0]     blank_cnt;
    logic              blanking;
    logic              enter_p, pause_p;
    logic              go_enter, go_pause, go_lose;
    logic              rec_d;

    logic [PIX_W-1:0]  pix_title, pix_record, pix_game, pix_over, pix_sel;
    logic [ADDR_W-1:0] adr_title, adr_record, adr_game, adr_over, adr_sel;
    logic              restart_d;

    logic [PIX_W-1:0]  pixel_q;
    logic [ADDR_W-1:0] pixel_addr_q;
    logic              restart_q, record_q, music_q;

    key_edge u_enter_edge (.clk(clk), .rst(rst), .key(bus.enter), .key_p(enter_p));
    key_edge u_pause_edge (.clk(clk), .rst(rst), .key(bus.pause), .key_p(pause_p));

    // keys and lose are dead while the screen is blanked
    assign blanking = (blank_cnt != '0);
    assign go_enter = enter_p  & ~blanking;
    assign go_pause = pause_p  & ~blanking;
    assign go_lose  = bus.lose & ~blanking;

    assign pix_title  = bus.pixel_in[SLOT_TITLE*PIX_W  +: PIX_W];
    assign pix_record = bus.pixel_in[SLOT_RECORD*PIX_W +: PIX_W];
    assign pix_game   = bus.pixel_in[SLOT_GAME*PIX_W   +: PIX_W];
    assign pix_over   = bus.pixel_in[SLOT_OVER*PIX_W   +: PIX_W];
    assign adr_title  = bus.pixel_addr_in[SLOT_TITLE*ADDR_W  +: ADDR_W];
    assign adr_record = bus.pixel_addr_in[SLOT_RECORD*ADDR_W +: ADDR_W];
    assign adr_game   = bus.pixel_addr_in[SLOT_GAME*ADDR_W   +: ADDR_W];
    assign adr_over   = bus.pixel_addr_in[SLOT_OVER*ADDR_W   +: ADDR_W];

`ifdef GAME_PAUSE_EN
    localparam int FW = PIX_W / 3;

    // halve each colour field independently
    function automatic logic [PIX_W-1:0] dim_pix(input logic [PIX_W-1:0] p);
        logic [PIX_W-1:0] r;
        r = '0;
        for (int f = 0; f < 3; f++) r[f*FW +: FW] = p[f*FW +: FW] >> 1;
        return r;
    endfunction
`endif

    // state register and blank timer (reloaded on any screen change)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_TITLE;
            blank_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) blank_cnt <= BLANK_LOAD;
            else if (blanking)      blank_cnt <= blank_cnt - BW'(1);
        end
    end

    // next-state logic; PAUSE exits are kept in both builds but the state
    // is only reachable with the pause feature enabled
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TITLE:  if (go_enter) state_d = bus.select ? S_RECORD : S_PLAY;
            S_RECORD: if (go_enter) state_d = S_TITLE;
            S_PLAY: begin
                if (go_lose) state_d = S_OVER;
`ifdef GAME_PAUSE_EN
                else if (go_pause) state_d = S_PAUSE;
`endif
            end
            S_OVER:   if (go_enter) state_d = S_TITLE;
            S_PAUSE: begin
                if (go_enter)      state_d = S_TITLE;
                else if (go_pause) state_d = S_PLAY;
            end
            default:  state_d = S_TITLE;
        endcase
    end

    assign rec_d = (state_q == S_PLAY) && (state_d == S_OVER);

`ifdef GAME_PAUSE_EN
    logic hold_d, hold_q;
`endif

    // per-state slot selection and restart level; bad codes look like TITLE
    always_comb begin
        pix_sel   = pix_title;
        adr_sel   = adr_title;
        restart_d = 1'b1;
`ifdef GAME_PAUSE_EN
        hold_d    = 1'b0;
`endif
        case (state_q)
            S_RECORD: begin
                pix_sel = pix_record;
                adr_sel = adr_record;
            end
            S_PLAY: begin
                pix_sel   = pix_game;
                adr_sel   = adr_game;
                restart_d = 1'b0;
            end
            S_OVER: begin
                pix_sel   = pix_over;
                adr_sel   = adr_over;
                restart_d = 1'b0;
            end
            S_PAUSE: begin
`ifdef GAME_PAUSE_EN
                pix_sel   = dim_pix(pix_game);
                hold_d    = 1'b1;
`else
                pix_sel   = pix_game;
`endif
                adr_sel   = adr_game;
                restart_d = 1'b0;
            end
            default: ;
        endcase
    end

    // output register: one cycle behind the state, black while blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q      <= '0;
            pixel_addr_q <= '0;
            restart_q    <= 1'b1;
            record_q     <= 1'b0;
            music_q      <= 1'b0;
        end else begin
            pixel_q      <= blanking ? '0 : pix_sel;
            pixel_addr_q <= adr_sel;
            restart_q    <= restart_d;
            record_q     <= rec_d;
            music_q      <= rec_d;
        end
    end

`ifdef GAME_PAUSE_EN
    // freeze the game core while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= 1'b0;
        else     hold_q <= hold_d;
    end
    assign bus.game_hold = hold_q;
`else
    assign bus.game_hold = 1'b0;
`endif

    assign bus.pixel      = pixel_q;
    assign bus.pixel_addr = pixel_addr_q;
    assign bus.restart    = restart_q;
    assign bus.record     = record_q;
    assign bus.music      = music_q;
    assign bus.screen     = state_q;
endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl: one instance with 16 blank cycles,
// one with blanking disabled.
module tb_game_screen_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst0 = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt, rec_n, mus_n;

    localparam logic [47:0] PIX  = {12'hD0D, 12'hABC, 12'h2E2, 12'h1F1};
    localparam logic [67:0] ADRS = {17'h10303, 17'h10202, 17'h10101, 17'h10001};

    always #5 clk = ~clk;

    game_screen_ctrl_if #(.PIX_W(12), .ADDR_W(17)) b16 ();
    game_screen_ctrl_if #(.PIX_W(12), .ADDR_W(17)) b0 ();

    game_screen_ctrl #(.PIX_W(12), .ADDR_W(17), .BLANK_CYCLES(16))
        u_dut  (.clk(clk), .rst(rst), .bus(b16));
    game_screen_ctrl #(.PIX_W(12), .ADDR_W(17), .BLANK_CYCLES(0))
        u_dut0 (.clk(clk), .rst(rst0), .bus(b0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b16.pixel_in = PIX; b16.pixel_addr_in = ADRS;
        b16.enter = 1'b1; b16.select = 1'b0; b16.lose = 1'b0; b16.pause = 1'b0;
        b0.pixel_in = PIX; b0.pixel_addr_in = ADRS;
        b0.enter = 1'b0; b0.select = 1'b0; b0.lose = 1'b0; b0.pause = 1'b0;

        // reset values, enter held through reset
        cyc(2);
        check("rst_screen",  32'(b16.screen), 0);
        check("rst_pixel",   32'(b16.pixel), 0);
        check("rst_addr",    32'(b16.pixel_addr), 0);
        check("rst_restart", 32'(b16.restart), 1);
        check("rst_record",  32'(b16.record), 0);
        check("rst_music",   32'(b16.music), 0);
        check("rst_hold",    32'(b16.game_hold), 0);
        rst = 1'b0; rst0 = 1'b0;
        cyc(3);
        check("held_no_fire", 32'(b16.screen), 0);
        check("title_pixel",  32'(b16.pixel), 32'h1F1);

        // press enter: TITLE -> PLAY, then 16 black cycles
        b16.enter = 1'b0; cyc(1);
        b16.enter = 1'b1; cyc(1);
        check("play_screen",  32'(b16.screen), 2);
        check("play_latency", 32'(b16.pixel), 32'h1F1);
        b16.enter = 1'b0; cyc(1);
        check("blank_addr",    32'(b16.pixel_addr), 32'h10202);
        check("blank_restart", 32'(b16.restart), 0);
        cnt = 0;
        while (b16.pixel == 12'h000 && cnt < 40) begin
            if (cnt == 3) b16.lose = 1'b1;
            if (cnt == 5) b16.lose = 1'b0;
            cnt++;
            cyc(1);
        end
        check("blank_len",       32'(cnt), 16);
        check("lose_in_blank",   32'(b16.screen), 2);
        check("play_pixel",      32'(b16.pixel), 32'hABC);
        check("play_restart",    32'(b16.restart), 0);

        // lose for 3 cycles -> single record/music pulse
        b16.lose = 1'b1; rec_n = 0; mus_n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            rec_n += int'(b16.record);
            mus_n += int'(b16.music);
            if (i == 2) b16.lose = 1'b0;
        end
        check("record_pulses", 32'(rec_n), 1);
        check("music_pulses",  32'(mus_n), 1);
        check("over_screen",   32'(b16.screen), 3);
        cyc(20);
        check("over_pixel",   32'(b16.pixel), 32'hD0D);
        check("over_addr",    32'(b16.pixel_addr), 32'h10303);
        check("over_restart", 32'(b16.restart), 0);
        b16.lose = 1'b1; rec_n = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            rec_n += int'(b16.record);
        end
        b16.lose = 1'b0;
        check("lose_in_over", 32'(rec_n), 0);
        check("over_stays",   32'(b16.screen), 3);

        // OVER -> TITLE; held enter must not fire once blanking ends
        b16.enter = 1'b1; b16.select = 1'b1; cyc(1);
        check("over_to_title", 32'(b16.screen), 0);
        cyc(25);
        check("held_across_blank", 32'(b16.screen), 0);
        check("title_restart",     32'(b16.restart), 1);

        // TITLE -> RECORD, press during blanking ignored, then back
        b16.enter = 1'b0; cyc(1);
        b16.enter = 1'b1; cyc(1);
        check("record_screen", 32'(b16.screen), 1);
        b16.enter = 1'b0; cyc(1);
        b16.enter = 1'b1; cyc(1);
        b16.enter = 1'b0; cyc(25);
        check("enter_in_blank", 32'(b16.screen), 1);
        check("record_pixel",   32'(b16.pixel), 32'h2E2);
        b16.enter = 1'b1; cyc(1);
        check("record_to_title", 32'(b16.screen), 0);
        b16.enter = 1'b0; b16.select = 1'b0;

        // no-blank instance: immediate switch, pause, reset mid-PLAY
        cyc(2);
        b0.enter = 1'b1; cyc(1);
        check("nb_screen",  32'(b0.screen), 2);
        check("nb_latency", 32'(b0.pixel), 32'h1F1);
        b0.enter = 1'b0; cyc(1);
        check("nb_pixel",   32'(b0.pixel), 32'hABC);
        check("nb_restart", 32'(b0.restart), 0);
`ifdef GAME_PAUSE_EN
        b0.pause = 1'b1; cyc(1);
        check("pause_screen", 32'(b0.screen), 4);
        b0.pause = 1'b0; cyc(1);
        check("pause_pixel", 32'(b0.pixel), 32'h556);
        check("pause_hold",  32'(b0.game_hold), 1);
        b0.pause = 1'b1; cyc(1);
        check("unpause_screen", 32'(b0.screen), 2);
        b0.pause = 1'b0; cyc(1);
`else
        b0.pause = 1'b1; cyc(1);
        check("pause_ignored", 32'(b0.screen), 2);
        b0.pause = 1'b0; cyc(1);
        check("no_hold",  32'(b0.game_hold), 0);
        check("no_dim",   32'(b0.pixel), 32'hABC);
`endif
        rst0 = 1'b1; #1;
        check("async_screen",  32'(b0.screen), 0);
        check("async_restart", 32'(b0.restart), 1);
        check("async_pixel",   32'(b0.pixel), 0);
        cyc(1);
        rst0 = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
